// File: rtl/starfield_ramp.sv
// Speed sequencer for the starfield: ramps the speed register toward a CPU-set target,
// one step every DIV vertical blanks. Optional readback mux: STARFIELD_RAMP_READBACK_EN.
//
// state  | meaning
// S_IDLE | current == target, frame counter held at 0
// S_WAIT | counting vblank edges until the next step
// S_EMIT | step write strobe is on sf_write this cycle
module starfield_ramp #(
    parameter int SPEED_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vblank,
    input  logic [1:0]         cpu_addr,
    input  logic [7:0]         cpu_data_in,
    input  logic               cpu_wr,
    output logic [7:0]         cpu_data_out,
    output logic [SPEED_W-1:0] sf_data,
    output logic               sf_write,
    output logic               busy
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EMIT} state_t;

    state_t             state_q, state_d;
    logic [SPEED_W-1:0] current_q, current_d;
    logic [SPEED_W-1:0] target_q, target_d;
    logic [SPEED_W-1:0] step_q, step_d;
    logic [7:0]         div_q, div_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
    logic               vb_q, vb_d;
    logic [SPEED_W-1:0] sf_data_q, sf_data_d;
    logic               sf_write_q, sf_write_d;
    logic               pend_q, pend_d;

    logic               vb_edge;
    logic               wr_target, wr_step, wr_div, ctrl_imm, ctrl_abort;
    logic [SPEED_W:0]   sum_up;
    logic [SPEED_W-1:0] step_val;

    assign busy     = (current_q != target_q);
    assign sf_data  = sf_data_q;
    assign sf_write = sf_write_q;

    always_comb begin
        vb_edge    = vblank & ~vb_q;
        wr_target  = cpu_wr && (cpu_addr == 2'd0);
        wr_step    = cpu_wr && (cpu_addr == 2'd1);
        wr_div     = cpu_wr && (cpu_addr == 2'd2);
        ctrl_imm   = cpu_wr && (cpu_addr == 2'd3) && cpu_data_in[0];
        ctrl_abort = cpu_wr && (cpu_addr == 2'd3) && cpu_data_in[1] && !cpu_data_in[0];

        // 9-bit arithmetic clamps at the target instead of wrapping
        sum_up = {1'b0, current_q} + {1'b0, step_q};
        if (target_q > current_q) begin
            step_val = (sum_up > {1'b0, target_q}) ? target_q : sum_up[SPEED_W-1:0];
        end else if ({1'b0, current_q} < ({1'b0, step_q} + {1'b0, target_q})) begin
            step_val = target_q;
        end else begin
            step_val = current_q - step_q;
        end

        state_d     = state_q;
        current_d   = current_q;
        target_d    = target_q;
        step_d      = step_q;
        div_d       = div_q;
        frame_cnt_d = frame_cnt_q;
        vb_d        = vblank;
        sf_data_d   = sf_data_q;
        sf_write_d  = 1'b0;
        pend_d      = 1'b0;

        if (wr_target) target_d = SPEED_W'(cpu_data_in);
        if (wr_step)   step_d   = (cpu_data_in == 8'd0) ? SPEED_W'(1) : SPEED_W'(cpu_data_in);
        if (wr_div)    div_d    = (cpu_data_in == 8'd0) ? 8'd1 : cpu_data_in;

        case (state_q)
            S_IDLE: begin
                frame_cnt_d = 8'd0;
                if (current_q != target_d) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (current_q == target_q) begin
                    state_d     = S_IDLE;
                    frame_cnt_d = 8'd0;
                end else if (vb_edge) begin
                    if (frame_cnt_q == div_q - 8'd1) begin
                        frame_cnt_d = 8'd0;
                        current_d   = step_val;
                        sf_data_d   = step_val;
                        sf_write_d  = 1'b1;
                        state_d     = S_EMIT;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
            S_EMIT: begin
                state_d = (current_q == target_q) ? S_IDLE : S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase

        // an IMMEDIATE that collided with a strobe is issued one cycle later
        if (pend_q) begin
            sf_write_d = 1'b1;
            sf_data_d  = current_q;
        end

        if (ctrl_imm) begin
            current_d   = target_q;
            state_d     = S_IDLE;
            frame_cnt_d = 8'd0;
            if (sf_write_q) begin
                pend_d     = 1'b1;
                sf_write_d = 1'b0;
                sf_data_d  = sf_data_q;
            end else begin
                sf_write_d = 1'b1;
                sf_data_d  = target_q;
            end
        end else if (ctrl_abort) begin
            current_d   = current_q;
            target_d    = current_q;
            state_d     = S_IDLE;
            frame_cnt_d = 8'd0;
            sf_write_d  = pend_q;
            sf_data_d   = pend_q ? current_q : sf_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            current_q   <= '0;
            target_q    <= '0;
            step_q      <= SPEED_W'(1);
            div_q       <= 8'd1;
            frame_cnt_q <= 8'd0;
            vb_q        <= 1'b0;
            sf_data_q   <= '0;
            sf_write_q  <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            current_q   <= current_d;
            target_q    <= target_d;
            step_q      <= step_d;
            div_q       <= div_d;
            frame_cnt_q <= frame_cnt_d;
            vb_q        <= vb_d;
            sf_data_q   <= sf_data_d;
            sf_write_q  <= sf_write_d;
            pend_q      <= pend_d;
        end
    end

`ifdef STARFIELD_RAMP_READBACK_EN
    logic [7:0] rdata_q, rdata_d;

    always_comb begin
        case (cpu_addr)
            2'd0:    rdata_d = 8'(current_q);
            2'd1:    rdata_d = 8'(step_q);
            2'd2:    rdata_d = div_q;
            default: rdata_d = {7'b0, busy};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) rdata_q <= 8'd0;
        else     rdata_q <= rdata_d;
    end

    assign cpu_data_out = rdata_q;
`else
    assign cpu_data_out = 8'd0;
`endif

endmodule

// File: tb/tb_starfield_ramp.sv
// Directed bench for starfield_ramp: ramp sequences, clamping, abort/immediate,
// concurrent CPU write on a step edge, and reset dominance.
module tb_starfield_ramp;

    logic       clk = 1'b0;
    logic       rst;
    logic       vblank;
    logic [1:0] cpu_addr;
    logic [7:0] cpu_data_in;
    logic       cpu_wr;
    logic [7:0] cpu_data_out;
    logic [7:0] sf_data;
    logic       sf_write;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef STARFIELD_RAMP_READBACK_EN
    localparam logic [7:0] RB_BUSY = 8'd1;
`else
    localparam logic [7:0] RB_BUSY = 8'd0;
`endif

    starfield_ramp #(.SPEED_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .vblank       (vblank),
        .cpu_addr     (cpu_addr),
        .cpu_data_in  (cpu_data_in),
        .cpu_wr       (cpu_wr),
        .cpu_data_out (cpu_data_out),
        .sf_data      (sf_data),
        .sf_write     (sf_write),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
        cpu_addr    = a;
        cpu_data_in = d;
        cpu_wr      = 1'b1;
        tick();
        cpu_wr      = 1'b0;
    endtask

    // one vblank pulse: edge sampled at E, strobe checked at E+1 and cleared at E+2
    task automatic frame(input string tag, input logic exp_w, input logic [7:0] exp_d);
        vblank = 1'b1;
        tick();
        chk({tag, "_sfw"}, sf_write, exp_w);
        if (exp_w) chk({tag, "_sfd"}, sf_data, exp_d);
        vblank = 1'b0;
        tick();
        chk({tag, "_sfw_off"}, sf_write, 1'b0);
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1; vblank = 1'b0; cpu_addr = 2'd0; cpu_data_in = 8'd0; cpu_wr = 1'b0;
        tick();
        tick();
        chk("rst_sfd", sf_data, 8'd0);
        chk("rst_sfw", sf_write, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rdata", cpu_data_out, 8'd0);
        rst = 1'b0;
        tick();

        // 0 -> 20, step 8, div 1
        cpu_write(2'd1, 8'd8);
        cpu_write(2'd2, 8'd1);
        cpu_write(2'd0, 8'd20);
        chk("t1_busy_up", busy, 1'b1);
        cpu_addr = 2'd3;
        tick();
        frame("t1_a", 1'b1, 8'd8);
        chk("t1_rb_busy", cpu_data_out, RB_BUSY);
        frame("t1_b", 1'b1, 8'd16);
        chk("t1_busy_mid", busy, 1'b1);
        vblank = 1'b1;
        tick();
        chk("t1_c_sfw", sf_write, 1'b1);
        chk("t1_c_sfd", sf_data, 8'd20);
        chk("t1_busy_done", busy, 1'b0);
        vblank = 1'b0;
        tick();
        tick();
        chk("t1_rb_idle", cpu_data_out, 8'd0);

        // 20 -> 0, step 5, div 3: write on every third edge
        cpu_write(2'd1, 8'd5);
        cpu_write(2'd2, 8'd3);
        cpu_write(2'd0, 8'd0);
        for (int i = 0; i < 12; i++) begin
            logic [7:0] exp_v;
            exp_v = 8'(20 - 5 * ((i + 1) / 3));
            frame($sformatf("t2_%0d", i), (i % 3) == 2, exp_v);
        end
        chk("t2_busy", busy, 1'b0);

        // clamping without wrap
        cpu_write(2'd2, 8'd1);
        cpu_write(2'd1, 8'd200);
        cpu_write(2'd0, 8'd100);
        frame("t3_100", 1'b1, 8'd100);
        cpu_write(2'd0, 8'd255);
        frame("t3_255", 1'b1, 8'd255);
        chk("t3_busy255", busy, 1'b0);
        cpu_write(2'd0, 8'd0);
        frame("t3_55", 1'b1, 8'd55);
        frame("t3_0", 1'b1, 8'd0);

        // abort mid-ramp, then immediate
        cpu_write(2'd1, 8'd10);
        cpu_write(2'd0, 8'd40);
        frame("t4_10", 1'b1, 8'd10);
        frame("t4_20", 1'b1, 8'd20);
        frame("t4_30", 1'b1, 8'd30);
        frame("t4_40", 1'b1, 8'd40);
        cpu_write(2'd0, 8'd200);
        frame("t4_50", 1'b1, 8'd50);
        cpu_write(2'd3, 8'd2);
        chk("t4_abort_busy", busy, 1'b0);
        chk("t4_abort_sfw", sf_write, 1'b0);
        frame("t4_after_abort", 1'b0, 8'd0);
        cpu_write(2'd0, 8'd90);
        cpu_write(2'd3, 8'd3);
        chk("t4_imm_sfw", sf_write, 1'b1);
        chk("t4_imm_sfd", sf_data, 8'd90);
        chk("t4_imm_busy", busy, 1'b0);
        tick();
        chk("t4_imm_sfw_off", sf_write, 1'b0);
        frame("t4_imm_idle", 1'b0, 8'd0);

        // STEP write on the step edge: step uses old value 10, new 30 used next
        cpu_write(2'd0, 8'd120);
        vblank = 1'b1; cpu_addr = 2'd1; cpu_data_in = 8'd30; cpu_wr = 1'b1;
        tick();
        cpu_wr = 1'b0; vblank = 1'b0;
        chk("t5_sfw", sf_write, 1'b1);
        chk("t5_sfd", sf_data, 8'd100);
        tick();
        tick();
        frame("t5_120", 1'b1, 8'd120);

        // STEP=0 is stored as 1
        cpu_write(2'd1, 8'd0);
        cpu_write(2'd0, 8'd122);
        frame("t6_121", 1'b1, 8'd121);
        frame("t6_122", 1'b1, 8'd122);
        chk("t6_busy", busy, 1'b0);

        // reset on a qualifying edge drops the step
        cpu_write(2'd0, 8'd0);
        cpu_addr = 2'd3;
        tick();
        vblank = 1'b1; rst = 1'b1;
        tick();
        chk("t7_sfw", sf_write, 1'b0);
        chk("t7_sfd", sf_data, 8'd0);
        chk("t7_busy", busy, 1'b0);
        chk("t7_rdata", cpu_data_out, 8'd0);
        rst = 1'b0; vblank = 1'b0;
        tick();
        chk("t7_sfw_after", sf_write, 1'b0);
        chk("t7_busy_after", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
